// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan capture block:
//   - active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F and blank
//   - FSM state encoding of the scan capture engine
//   - digit count and helpers that interpret the active-low digit enables
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // All digit enables inactive (active-low).
    localparam logic [NUM_DIGITS-1:0] AN_NONE = 4'hF;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] PAT_0     = 7'h40;
    localparam logic [6:0] PAT_1     = 7'h79;
    localparam logic [6:0] PAT_2     = 7'h24;
    localparam logic [6:0] PAT_3     = 7'h30;
    localparam logic [6:0] PAT_4     = 7'h19;
    localparam logic [6:0] PAT_5     = 7'h12;
    localparam logic [6:0] PAT_6     = 7'h02;
    localparam logic [6:0] PAT_7     = 7'h78;
    localparam logic [6:0] PAT_8     = 7'h00;
    localparam logic [6:0] PAT_9     = 7'h10;
    localparam logic [6:0] PAT_A     = 7'h08;
    localparam logic [6:0] PAT_B     = 7'h03;
    localparam logic [6:0] PAT_C     = 7'h46;
    localparam logic [6:0] PAT_D     = 7'h21;
    localparam logic [6:0] PAT_E     = 7'h06;
    localparam logic [6:0] PAT_F     = 7'h0E;
    localparam logic [6:0] PAT_BLANK = 7'h7F;

    // IDLE: no digit enabled; SETTLE: waiting for a stable window;
    // HELD: captured, waiting for the next change of an/seg.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // True when exactly one active-low enable is asserted.
    function automatic logic single_digit(input logic [NUM_DIGITS-1:0] an);
        logic [NUM_DIGITS-1:0] sel;
        sel = ~an;
        return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    endfunction

    // Index of the (lowest) asserted active-low enable.
    function automatic logic [1:0] digit_index(input logic [NUM_DIGITS-1:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational decode of an active-low seven-segment pattern to a hex value.
// Ports:
//   seg      [6:0] in  : active-low segments {g,f,e,d,c,b,a}
//   value    [3:0] out : decoded hex value (0 when blank or undecodable)
//   is_blank       out : all segments off
//   valid          out : pattern is one of the 16 hex glyphs or blank
// -----------------------------------------------------------------------------
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       is_blank,
    output logic       valid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        value    = 4'h0;
        is_blank = 1'b0;
        valid    = 1'b1;
        case (seg)
            PAT_0:     value = 4'h0;
            PAT_1:     value = 4'h1;
            PAT_2:     value = 4'h2;
            PAT_3:     value = 4'h3;
            PAT_4:     value = 4'h4;
            PAT_5:     value = 4'h5;
            PAT_6:     value = 4'h6;
            PAT_7:     value = 4'h7;
            PAT_8:     value = 4'h8;
            PAT_9:     value = 4'h9;
            PAT_A:     value = 4'hA;
            PAT_B:     value = 4'hB;
            PAT_C:     value = 4'hC;
            PAT_D:     value = 4'hD;
            PAT_E:     value = 4'hE;
            PAT_F:     value = 4'hF;
            PAT_BLANK: is_blank = 1'b1;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// seg7_scan_capture
// Observes a multiplexed 4-digit seven-segment display bus and reconstructs
// the displayed hex digits. A digit is captured once its an/seg value has been
// stable for STABLE_CYCLES registered samples (STABLE_CYCLES must be >= 2).
// Parameters:
//   STABLE_CYCLES  : identical samples required before a capture
//   TIMEOUT_CYCLES : cycles without capture before stale is raised
// Ports:
//   clk              in  : clock, rising edge
//   rst              in  : asynchronous active-high reset
//   an         [3:0] in  : active-low digit enables, bit i = digit i
//   seg        [7:0] in  : active-low segments {dp,g,f,e,d,c,b,a}
//   digit     [15:0] out : captured hex values, digit i in [4i+3:4i]
//   dp         [3:0] out : captured decimal points, active-high
//   blank      [3:0] out : digit i last captured with all segments off
//   frame_done       out : pulse when all four digits captured since last pulse
//   err              out : pulse on a capture with several digits enabled or
//                          an undecodable pattern
//   stale            out : no capture for TIMEOUT_CYCLES cycles
// -----------------------------------------------------------------------------
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] digit,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        frame_done,
    output logic        err,
    output logic        stale
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0]  TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    state_t         state;
    logic [3:0]     an_q;       // input register
    logic [7:0]     seg_q;
    logic [3:0]     an_l;       // previous registered sample, for change detect
    logic [7:0]     seg_l;
    logic [SCW-1:0] stab_cnt;   // samples the current value has been held
    logic [TW-1:0]  tmo_cnt;
    logic [3:0]     seen;

    logic [3:0]     dec_value;
    logic           dec_blank;
    logic           dec_valid;
    logic           changed;
    logic           capture;
    logic           legal;
    logic [1:0]     idx;
    logic [3:0]     seen_next;
    logic [TW-1:0]  tmo_next;

    seg7_pattern_decode u_decode (
        .seg      (seg_q[6:0]),
        .value    (dec_value),
        .is_blank (dec_blank),
        .valid    (dec_valid)
    );

    assign changed = {an_q, seg_q} != {an_l, seg_l};
    // A change on the completing cycle wins, so that window yields no capture.
    assign capture = (state == SETTLE) && !changed && (stab_cnt == STABLE_LAST);
    assign legal   = single_digit(an_q) && dec_valid;
    assign idx     = digit_index(an_q);
    assign seen_next = seen | (4'b0001 << idx);
    assign tmo_next  = (tmo_cnt == TIMEOUT_MAX) ? tmo_cnt : tmo_cnt + 1'b1;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Input registers reset to the "nothing displayed" value so the
            // first real sample after release counts as a change and starts
            // a full stability window.
            an_q       <= AN_NONE;
            seg_q      <= 8'hFF;
            an_l       <= AN_NONE;
            seg_l      <= 8'hFF;
            state      <= IDLE;
            stab_cnt   <= '0;
            tmo_cnt    <= '0;
            seen       <= '0;
            digit      <= '0;
            dp         <= '0;
            blank      <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            stale      <= 1'b0;
        end else begin
            an_q       <= an;
            seg_q      <= seg;
            an_l       <= an_q;
            seg_l      <= seg_q;
            frame_done <= 1'b0;
            err        <= 1'b0;

            // Stability FSM. The changed sample itself is the first sample
            // of the new window, hence the restart value of 1.
            if (changed) begin
                stab_cnt <= SCW'(1);
                state    <= (an_q == AN_NONE) ? IDLE : SETTLE;
            end else begin
                case (state)
                    SETTLE: begin
                        if (stab_cnt == STABLE_LAST) state <= HELD;
                        else                         stab_cnt <= stab_cnt + 1'b1;
                    end
                    IDLE:    state <= IDLE;
                    HELD:    state <= HELD;
                    default: state <= IDLE;
                endcase
            end

            // Capture and timeout.
            if (capture) begin
                tmo_cnt <= '0;
                stale   <= 1'b0;
                if (legal) begin
                    if (!dec_blank) digit[{idx, 2'b00} +: 4] <= dec_value;
                    dp[idx]    <= ~seg_q[7];
                    blank[idx] <= dec_blank;
                    if (seen_next == 4'hF) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                    end else begin
                        seen <= seen_next;
                    end
                end else begin
                    err <= 1'b1;
                end
            end else begin
                tmo_cnt <= tmo_next;
                stale   <= (tmo_next == TIMEOUT_MAX);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_capture
// Directed, table-driven bench for seg7_scan_capture (STABLE_CYCLES = 4,
// TIMEOUT_CYCLES = 32). Expected values are hand-computed from the active-low
// segment encoding; dp is on when seg[7] is low.
// -----------------------------------------------------------------------------
module tb_seg7_scan_capture;

    logic        clk;
    logic        rst;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digit;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        frame_done;
    logic        err;
    logic        stale;

    int checks;
    int errors;
    int fd_cnt;
    int err_cnt;

    seg7_scan_capture #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .an         (an),
        .seg        (seg),
        .digit      (digit),
        .dp         (dp),
        .blank      (blank),
        .frame_done (frame_done),
        .err        (err),
        .stale      (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (frame_done) fd_cnt++;
            if (err)        err_cnt++;
        end
    end

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  seg;
        logic [15:0] exp_digit;
        logic [3:0]  exp_dp;
        logic [3:0]  exp_blank;
        int          exp_err;
        int          exp_fd;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Show a value for 'hold' cycles, then blank the bus for 2 cycles.
    task automatic show(input logic [3:0] a, input logic [7:0] s, input int hold);
        an  = a;
        seg = s;
        step(hold);
        an  = 4'hF;
        seg = 8'hFF;
        step(2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " digit"},      32'(digit),      32'h0);
        check({tag, " dp"},         32'(dp),         32'h0);
        check({tag, " blank"},      32'(blank),      32'h0);
        check({tag, " frame_done"}, 32'(frame_done), 32'h0);
        check({tag, " err"},        32'(err),        32'h0);
        check({tag, " stale"},      32'(stale),      32'h0);
    endtask

    initial begin
        int fd0;
        int err0;
        checks  = 0;
        errors  = 0;
        fd_cnt  = 0;
        err_cnt = 0;

        //           an     seg     digit     dp    blank  err fd
        vecs[0]  = '{4'hE, 8'h12, 16'h0005, 4'h1, 4'h0, 0, 0}; // 5, dp on
        vecs[1]  = '{4'hD, 8'h88, 16'h00A5, 4'h1, 4'h0, 0, 0}; // A
        vecs[2]  = '{4'hE, 8'h86, 16'h00AE, 4'h0, 4'h0, 0, 0}; // re-capture E
        vecs[3]  = '{4'hB, 8'hFF, 16'h00AE, 4'h0, 4'h4, 0, 0}; // blank
        vecs[4]  = '{4'h7, 8'h0E, 16'hF0AE, 4'h8, 4'h4, 0, 1}; // F, dp, frame
        vecs[5]  = '{4'h7, 8'hA1, 16'hD0AE, 4'h0, 4'h4, 0, 0}; // d
        vecs[6]  = '{4'hE, 8'hFE, 16'hD0AE, 4'h0, 4'h4, 1, 0}; // undecodable
        vecs[7]  = '{4'h3, 8'hC0, 16'hD0AE, 4'h0, 4'h4, 1, 0}; // two digits on
        vecs[8]  = '{4'hB, 8'hC6, 16'hDCAE, 4'h0, 4'h0, 0, 0}; // C
        vecs[9]  = '{4'hD, 8'h83, 16'hDCBE, 4'h0, 4'h0, 0, 0}; // b
        vecs[10] = '{4'hE, 8'h80, 16'hDCB8, 4'h0, 4'h0, 0, 1}; // 8, frame
        vecs[11] = '{4'h7, 8'h90, 16'h9CB8, 4'h0, 4'h0, 0, 0}; // 9
        vecs[12] = '{4'hB, 8'h99, 16'h94B8, 4'h0, 4'h0, 0, 0}; // 4
        vecs[13] = '{4'hD, 8'h82, 16'h9468, 4'h0, 4'h0, 0, 0}; // 6
        vecs[14] = '{4'hE, 8'hF8, 16'h9467, 4'h0, 4'h0, 0, 1}; // 7, frame

        // Reset state.
        rst = 1'b1;
        an  = 4'hF;
        seg = 8'hFF;
        step(3);
        check_zero("reset");
        rst = 1'b0;
        step(2);

        // Table-driven captures.
        foreach (vecs[i]) begin
            fd0  = fd_cnt;
            err0 = err_cnt;
            show(vecs[i].an, vecs[i].seg, 8);
            check($sformatf("vec%0d digit", i), 32'(digit), 32'(vecs[i].exp_digit));
            check($sformatf("vec%0d dp", i),    32'(dp),    32'(vecs[i].exp_dp));
            check($sformatf("vec%0d blank", i), 32'(blank), 32'(vecs[i].exp_blank));
            check($sformatf("vec%0d err pulses", i), 32'(err_cnt - err0), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d frame pulses", i), 32'(fd_cnt - fd0), 32'(vecs[i].exp_fd));
        end

        // Continuous scan of 0,1,2,3 across digits 0..3.
        fd0  = fd_cnt;
        err0 = err_cnt;
        an = 4'hE; seg = 8'hC0; step(8);
        an = 4'hD; seg = 8'hF9; step(8);
        an = 4'hB; seg = 8'hA4; step(8);
        an = 4'h7; seg = 8'hB0; step(8);
        an = 4'hF; seg = 8'hFF; step(2);
        check("scan digit",        32'(digit),           32'h3210);
        check("scan dp",           32'(dp),              32'h0);
        check("scan frame pulses", 32'(fd_cnt - fd0),    32'd1);
        check("scan err pulses",   32'(err_cnt - err0),  32'd0);

        // Short-lived 0 (dp on) must not be captured; the change lands on the
        // cycle the window would complete. 8'h92 has its dp segment off.
        an = 4'hE; seg = 8'h40; step(3);
        check("glitch dp0",    32'(dp[0]), 32'h0);
        check("glitch digit",  32'(digit), 32'h3210);
        seg = 8'h92; step(8);
        an = 4'hF; seg = 8'hFF; step(2);
        check("switch digit0", 32'(digit[3:0]), 32'h5);
        check("switch dp0",    32'(dp[0]),      32'h0);

        // Two digits enabled at once.
        err0 = err_cnt;
        fd0  = fd_cnt;
        show(4'hC, 8'hC0, 8);
        check("multi err pulses",   32'(err_cnt - err0), 32'd1);
        check("multi digit",        32'(digit),          32'h3215);
        check("multi frame pulses", 32'(fd_cnt - fd0),   32'd0);

        // Blank digit 2 keeps its value field.
        show(4'hB, 8'hFF, 8);
        check("blank2 blank",   32'(blank),        32'h4);
        check("blank2 digit2",  32'(digit[11:8]),  32'h2);

        // Stale after 32 capture-free cycles, cleared by a legal capture.
        step(15);
        check("stale early", 32'(stale), 32'h0);
        step(20);
        check("stale set",   32'(stale), 32'h1);
        show(4'h7, 8'hA4, 8);
        check("stale clear", 32'(stale), 32'h0);
        check("stale digit", 32'(digit), 32'h2215);

        // Reset two samples into a stability window.
        an = 4'h7; seg = 8'hF9;
        step(3);
        rst = 1'b1;
        #1;
        check_zero("midsettle");
        step(1);
        rst = 1'b0;
        step(4);
        check("post-reset early", 32'(digit), 32'h0);
        step(1);
        check("post-reset capture", 32'(digit), 32'h1000);
        an = 4'hF; seg = 8'hFF;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
